// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM control fields and cache status in,
// per-stage bubble/flush, miss status and performance counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic             rs1_read_D;
    logic             rs2_read_D;
    logic [4:0]       rd_EX;
    logic             cache_read_en_EX;
    logic             br_taken_EX;
    logic             jalr_EX;
    logic             jal_D;
    logic             cache_req_MEM;
    logic             cache_miss;
    logic             cache_ready;

    logic             bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic             flushF, flushD, flushE, flushM, flushW;
    logic             miss_stall;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] miss_count;

    // Datapath side: supplies pipeline control state, consumes stall/flush.
    modport master (
        output rs1_D, rs2_D, rs1_read_D, rs2_read_D, rd_EX, cache_read_en_EX,
               br_taken_EX, jalr_EX, jal_D, cache_req_MEM, cache_miss, cache_ready,
        input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW,
               miss_stall, timeout_err, stall_cycles, miss_count
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_read_D, rs2_read_D, rd_EX, cache_read_en_EX,
               br_taken_EX, jalr_EX, jal_D, cache_req_MEM, cache_miss, cache_ready,
        output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW,
               miss_stall, timeout_err, stall_cycles, miss_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline: load-use,
// branch/jump redirect and data-cache miss handling with a timeout watchdog.
module pipeline_hazard_ctrl #(
    parameter int MISS_TIMEOUT = 256,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = (MISS_TIMEOUT > 2) ? $clog2(MISS_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RESUME    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic               timeout_err_reg;
    logic [CNT_W-1:0]   stall_cycles_reg;
    logic [CNT_W-1:0]   miss_count_reg;

    logic               miss_start;
    logic               miss_active;
    logic               redirect;
    logic               load_use;
    logic [1:0]         src_hit;
    logic [1:0][4:0]    src_reg;
    logic [1:0]         src_read;
    // Stage vectors are ordered {F, D, E, M, W}.
    logic [4:0]         bubble_vec;
    logic [4:0]         flush_vec;

    assign src_reg  = {hz.rs2_D, hz.rs1_D};
    assign src_read = {hz.rs2_read_D, hz.rs1_read_D};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_read[gi] & (src_reg[gi] == hz.rd_EX);
        end
    endgenerate

    // A miss arriving in RESUME is deliberately not seen until IDLE.
    assign miss_start  = (state_reg == IDLE) & hz.cache_req_MEM & hz.cache_miss;
    assign miss_active = (state_reg == MISS_WAIT) | miss_start;
    assign redirect    = hz.br_taken_EX | hz.jalr_EX;
    assign load_use    = hz.cache_read_en_EX & (hz.rd_EX != 5'd0) & (|src_hit);

    always_comb begin
        bubble_vec = 5'b00000;
        flush_vec  = 5'b00000;
        if (!rst_n) begin
            flush_vec = 5'b11111;
        end else if (miss_active) begin
            bubble_vec = 5'b11110;
            flush_vec  = 5'b00001;
        end else if (redirect) begin
            flush_vec = 5'b01100;
        end else if (load_use) begin
            bubble_vec = 5'b11000;
            flush_vec  = 5'b00100;
        end else if (hz.jal_D) begin
            flush_vec = 5'b01000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= '0;
            timeout_err_reg  <= 1'b0;
            stall_cycles_reg <= '0;
            miss_count_reg   <= '0;
        end else begin
            if (|bubble_vec)
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (miss_start) begin
                        state_reg      <= MISS_WAIT;
                        wait_cnt_reg   <= '0;
                        miss_count_reg <= miss_count_reg + 1'b1;
                    end
                end
                MISS_WAIT: begin
                    if (hz.cache_ready) begin
                        state_reg <= RESUME;
                    end else if (wait_cnt_reg == WAIT_W'(MISS_TIMEOUT - 1)) begin
                        // Counter parks at the limit; the FSM keeps waiting for the refill.
                        timeout_err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                RESUME:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign hz.bubbleF      = bubble_vec[4];
    assign hz.bubbleD      = bubble_vec[3];
    assign hz.bubbleE      = bubble_vec[2];
    assign hz.bubbleM      = bubble_vec[1];
    assign hz.bubbleW      = bubble_vec[0];
    assign hz.flushF       = flush_vec[4];
    assign hz.flushD       = flush_vec[3];
    assign hz.flushE       = flush_vec[2];
    assign hz.flushM       = flush_vec[1];
    assign hz.flushW       = flush_vec[0];
    assign hz.miss_stall   = rst_n & miss_active;
    assign hz.timeout_err  = timeout_err_reg;
    assign hz.stall_cycles = stall_cycles_reg;
    assign hz.miss_count   = miss_count_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard/miss scenarios plus
// random traffic, checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int TOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz();

    pipeline_hazard_ctrl #(.MISS_TIMEOUT(TOUT), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1, rs2;
        logic       rs1r, rs2r;
        logic [4:0] rd;
        logic       ld, br, jalr, jal, req, miss, ready;
    } stim_t;

    typedef struct packed {
        logic        bF, bD, bE, bM, bW;
        logic        fF, fD, fE, fM, fW;
        logic        ms, te;
        logic [31:0] sc, mc;
    } resp_t;

    resp_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    txn      = 0;

    // Behavioural model: "waiting for refill", "one quiet cycle after refill",
    // number of unanswered wait cycles, plus sticky error and counters.
    bit          m_waiting = 0;
    bit          m_resumed = 0;
    int          m_waited  = 0;
    bit          m_tout    = 0;
    logic [31:0] m_stall   = 0;
    logic [31:0] m_miss    = 0;

    function automatic bit chance(int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    function automatic stim_t quiet();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n = !chance(2);
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.rd    = 5'($urandom_range(0, 3));
        s.rs1r  = chance(60);
        s.rs2r  = chance(60);
        s.ld    = chance(50);
        s.br    = chance(15);
        s.jalr  = chance(5);
        s.jal   = chance(15);
        s.req   = chance(50);
        s.miss  = chance(20);
        s.ready = chance(30);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        resp_t e;
        bit    stalled, lu;
        @(posedge clk);
        #1;
        rst_n                = s.rst_n;
        hz.rs1_D             = s.rs1;
        hz.rs2_D             = s.rs2;
        hz.rs1_read_D        = s.rs1r;
        hz.rs2_read_D        = s.rs2r;
        hz.rd_EX             = s.rd;
        hz.cache_read_en_EX  = s.ld;
        hz.br_taken_EX       = s.br;
        hz.jalr_EX           = s.jalr;
        hz.jal_D             = s.jal;
        hz.cache_req_MEM     = s.req;
        hz.cache_miss        = s.miss;
        hz.cache_ready       = s.ready;

        e    = '0;
        e.te = m_tout;
        e.sc = m_stall;
        e.mc = m_miss;
        if (!s.rst_n) begin
            {e.fF, e.fD, e.fE, e.fM, e.fW} = 5'b11111;
            m_waiting = 0; m_resumed = 0; m_waited = 0;
            m_tout = 0; m_stall = 0; m_miss = 0;
        end else begin
            stalled = m_waiting || (!m_resumed && s.req && s.miss);
            lu = s.ld && (s.rd != 0) &&
                 ((s.rs1r && s.rs1 == s.rd) || (s.rs2r && s.rs2 == s.rd));
            if (stalled) begin
                e.bF = 1; e.bD = 1; e.bE = 1; e.bM = 1; e.fW = 1; e.ms = 1;
            end else if (s.br || s.jalr) begin
                e.fD = 1; e.fE = 1;
            end else if (lu) begin
                e.bF = 1; e.bD = 1; e.fE = 1;
            end else if (s.jal) begin
                e.fD = 1;
            end
            if (e.bF || e.bD || e.bE || e.bM || e.bW)
                m_stall = m_stall + 1;
            if (m_waiting) begin
                if (s.ready) begin
                    m_waiting = 0;
                    m_resumed = 1;
                end else begin
                    m_waited++;
                    if (m_waited >= TOUT) m_tout = 1;
                end
            end else if (m_resumed) begin
                m_resumed = 0;
            end else if (s.req && s.miss) begin
                m_waiting = 1;
                m_waited  = 0;
                m_miss    = m_miss + 1;
            end
        end
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a response; compare it at the falling edge.
    initial begin
        resp_t a, e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = '{hz.bubbleF, hz.bubbleD, hz.bubbleE, hz.bubbleM, hz.bubbleW,
                      hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW,
                      hz.miss_stall, hz.timeout_err, hz.stall_cycles, hz.miss_count};
                checks++;
                txn++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL hazard_outputs txn=%0d got=%h want=%h", txn, a, e);
                end else begin
                    $display("txn %0d ok resp=%h", txn, a);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        s = '0;
        {hz.rs1_D, hz.rs2_D, hz.rs1_read_D, hz.rs2_read_D, hz.rd_EX} = '0;
        {hz.cache_read_en_EX, hz.br_taken_EX, hz.jalr_EX, hz.jal_D} = '0;
        {hz.cache_req_MEM, hz.cache_miss, hz.cache_ready} = '0;
        repeat (2) @(posedge clk);

        // Reset state while held.
        s = quiet(); s.rst_n = 0; drive(s);
        drive(quiet());

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        s = quiet(); s.ld = 1; s.rd = 5; s.rs1 = 5; s.rs1r = 1; s.rs2 = 1; s.rs2r = 1;
        drive(s);
        // rd_EX = 0 never hazards.
        s.rd = 0; s.rs1 = 0; drive(s);
        // Load-use match plus taken branch: redirect wins.
        s = quiet(); s.ld = 1; s.rd = 7; s.rs2 = 7; s.rs2r = 1; s.br = 1; drive(s);
        s = quiet(); s.jal = 1; drive(s);

        // Miss with refill on the fifth wait cycle, branch during the wait and at resume.
        s = quiet(); s.req = 1; s.miss = 1; drive(s);
        for (int i = 0; i < 4; i++) begin
            s = quiet(); s.br = (i == 2); drive(s);
        end
        s = quiet(); s.ready = 1; drive(s);
        s = quiet(); s.br = 1; s.req = 1; s.miss = 1; drive(s);
        drive(quiet());
        drive(quiet());

        // Reset mid-miss.
        s = quiet(); s.req = 1; s.miss = 1; drive(s);
        drive(quiet());
        drive(quiet());
        s = quiet(); s.rst_n = 0; drive(s);
        drive(quiet());

        // Random traffic.
        for (int i = 0; i < 600; i++) drive(rand_stim());

        // Timeout: refill never arrives, error is sticky until reset.
        s = quiet(); s.rst_n = 0; drive(s);
        s = quiet(); s.req = 1; s.miss = 1; drive(s);
        for (int i = 0; i < 10; i++) drive(quiet());
        s = quiet(); s.ready = 1; drive(s);
        drive(quiet());
        drive(quiet());
        s = quiet(); s.rst_n = 0; drive(s);
        drive(quiet());
        drive(quiet());

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
